pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage. Holds the current fetch PC and advances it by the instruction width whenever `trigger` is asserted. Accepts branch/jump redirects and trap entry, checks target alignment, and keeps a redirect epoch counter so downstream stages can drop wrong-path instructions. It supersedes the plain PC register and feeds instruction memory and the IF/ID pipeline register.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/pc_next_sel.sv | 63 ++++++
 rtl/pc_gen.sv | 77 +++++++
 tb/tb_pc_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants used by the program-counter generator.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } pc_state_e;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

   // Number of low PC bits that must be zero for an aligned fetch address.
   function automatic int align_bits(input int instr_bytes);
      return $clog2(instr_bytes);
   endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux and fetch FSM next-state logic; purely combinational.
import fetch_pkg::*;

module pc_next_sel #(
   parameter int                    DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = DATA_WIDTH'(DEFAULT_TRAP_VECTOR),
   parameter int                    INSTR_BYTES = 4
) (
   input  logic [DATA_WIDTH-1:0] pc,
   input  logic [DATA_WIDTH-1:0] pc_plus_inc,
   input  pc_state_e             state,
   input  logic                  trigger,
   input  logic                  halt_req,
   input  logic                  redirect_en,
   input  logic [DATA_WIDTH-1:0] redirect_target,
   input  logic                  trap_en,
   output logic [DATA_WIDTH-1:0] pc_next,
   output pc_state_e             state_next,
   output logic                  epoch_inc,
   output logic                  fault
);

   localparam int ALIGN_BITS = align_bits(INSTR_BYTES);

   logic misaligned;
   assign misaligned = |redirect_target[ALIGN_BITS-1:0];

   always_comb begin
      pc_next    = pc;
      state_next = state;
      epoch_inc  = 1'b0;
      fault      = 1'b0;
      // Trap and redirect win in every state and ignore trigger, so a stall never drops them.
      if (trap_en) begin
         pc_next    = TRAP_VECTOR;
         state_next = RUN;
         epoch_inc  = 1'b1;
      end else if (redirect_en) begin
         state_next = RUN;
         epoch_inc  = 1'b1;
         if (misaligned) begin
            pc_next = TRAP_VECTOR;
            fault   = 1'b1;
         end else begin
            pc_next = redirect_target;
         end
      end else begin
         case (state)
            BOOT:    state_next = RUN;
            RUN: begin
               if (halt_req) begin
                  state_next = HALTED;
               end else if (trigger) begin
                  pc_next = pc_plus_inc;
               end
            end
            HALTED:  state_next = HALTED;
            default: state_next = BOOT;
         endcase
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: sequential advance, redirects, traps,
// alignment checking and a redirect epoch tag for wrong-path squashing.
import fetch_pkg::*;

module pc_gen #(
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(DEFAULT_RESET_VECTOR),
   parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = DATA_WIDTH'(DEFAULT_TRAP_VECTOR),
   parameter int                    INSTR_BYTES  = 4,
   parameter int                    EPOCH_WIDTH  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   trigger,
   input  logic                   halt_req,
   input  logic                   redirect_en,
   input  logic [DATA_WIDTH-1:0]  redirect_target,
   input  logic                   trap_en,
   output logic [DATA_WIDTH-1:0]  pc_out,
   output logic [DATA_WIDTH-1:0]  pc_plus_inc,
   output logic                   pc_valid,
   output logic [EPOCH_WIDTH-1:0] epoch,
   output logic                   misalign_fault
);

   pc_state_e             state;
   pc_state_e             state_next;
   logic [DATA_WIDTH-1:0] pc_next;
   logic                  epoch_inc;
   logic                  fault;

   assign pc_plus_inc = pc_out + DATA_WIDTH'(INSTR_BYTES);

   pc_next_sel #(
      .DATA_WIDTH  (DATA_WIDTH),
      .TRAP_VECTOR (TRAP_VECTOR),
      .INSTR_BYTES (INSTR_BYTES)
   ) u_next_sel (
      .pc              (pc_out),
      .pc_plus_inc     (pc_plus_inc),
      .state           (state),
      .trigger         (trigger),
      .halt_req        (halt_req),
      .redirect_en     (redirect_en),
      .redirect_target (redirect_target),
      .trap_en         (trap_en),
      .pc_next         (pc_next),
      .state_next      (state_next),
      .epoch_inc       (epoch_inc),
      .fault           (fault)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_out         <= RESET_VECTOR;
         epoch          <= '0;
         misalign_fault <= 1'b0;
      end else begin
         pc_out         <= pc_next;
         epoch          <= epoch + EPOCH_WIDTH'(epoch_inc);
         misalign_fault <= fault;
      end
   end

   always_comb begin
      pc_valid = (state == RUN);
   end

endmodule

// File: tb/tb_pc_gen.sv
// Directed, table-driven bench for pc_gen; a second instance with 2-byte
// instructions shares the stimulus to cover the alignment rule.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        trigger;
   logic        halt_req;
   logic        redirect_en;
   logic [31:0] redirect_target;
   logic        trap_en;

   logic [31:0] pc_out,  pc_plus_inc;
   logic        pc_valid, misalign_fault;
   logic [1:0]  epoch;
   logic [31:0] pc_out2, pc_plus_inc2;
   logic        pc_valid2, misalign_fault2;
   logic [1:0]  epoch2;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic        trig;
      logic        halt;
      logic        redir;
      logic        trap;
      logic [31:0] tgt;
      logic [31:0] exp_pc;
      logic        exp_valid;
      logic [1:0]  exp_ep;
      logic        exp_fault;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   pc_gen dut (
      .clk             (clk),
      .rst             (rst),
      .trigger         (trigger),
      .halt_req        (halt_req),
      .redirect_en     (redirect_en),
      .redirect_target (redirect_target),
      .trap_en         (trap_en),
      .pc_out          (pc_out),
      .pc_plus_inc     (pc_plus_inc),
      .pc_valid        (pc_valid),
      .epoch           (epoch),
      .misalign_fault  (misalign_fault)
   );

   pc_gen #(.INSTR_BYTES(2)) dut2 (
      .clk             (clk),
      .rst             (rst),
      .trigger         (trigger),
      .halt_req        (halt_req),
      .redirect_en     (redirect_en),
      .redirect_target (redirect_target),
      .trap_en         (trap_en),
      .pc_out          (pc_out2),
      .pc_plus_inc     (pc_plus_inc2),
      .pc_valid        (pc_valid2),
      .epoch           (epoch2),
      .misalign_fault  (misalign_fault2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic trig, input logic halt, input logic redir,
                        input logic trap, input logic [31:0] tgt);
      trigger         = trig;
      halt_req        = halt;
      redirect_en     = redir;
      trap_en         = trap;
      redirect_target = tgt;
   endtask

   task automatic add(input logic trig, input logic halt, input logic redir, input logic trap,
                      input logic [31:0] tgt, input logic [31:0] exp_pc, input logic exp_valid,
                      input logic [1:0] exp_ep, input logic exp_fault);
      vec_t v;
      v.trig = trig; v.halt = halt; v.redir = redir; v.trap = trap; v.tgt = tgt;
      v.exp_pc = exp_pc; v.exp_valid = exp_valid; v.exp_ep = exp_ep; v.exp_fault = exp_fault;
      vecs.push_back(v);
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                            input logic [1:0] e_ep, input logic e_fault);
      chk({tag, ".pc_out"},         pc_out,                 e_pc);
      chk({tag, ".pc_plus_inc"},    pc_plus_inc,            e_pc + 32'd4);
      chk({tag, ".pc_valid"},       32'(pc_valid),          32'(e_valid));
      chk({tag, ".epoch"},          32'(epoch),             32'(e_ep));
      chk({tag, ".misalign_fault"}, 32'(misalign_fault),    32'(e_fault));
   endtask

   initial begin
      //      trig halt redir trap target        exp_pc        vld ep fault
      add(1, 0, 0, 0, 32'h0,         32'h0000_0000, 1, 0, 0); // BOOT -> RUN, PC held
      add(1, 0, 0, 0, 32'h0,         32'h0000_0004, 1, 0, 0);
      add(1, 0, 0, 0, 32'h0,         32'h0000_0008, 1, 0, 0);
      add(0, 0, 0, 0, 32'h0,         32'h0000_0008, 1, 0, 0); // stall x3
      add(0, 0, 0, 0, 32'h0,         32'h0000_0008, 1, 0, 0);
      add(0, 0, 0, 0, 32'h0,         32'h0000_0008, 1, 0, 0);
      add(0, 0, 1, 0, 32'h40,        32'h0000_0040, 1, 1, 0); // redirect during stall
      add(0, 0, 1, 0, 32'h42,        32'h0000_0100, 1, 2, 1); // misaligned
      add(0, 0, 1, 0, 32'h42,        32'h0000_0100, 1, 3, 1); // back-to-back pulse
      add(1, 0, 0, 0, 32'h0,         32'h0000_0104, 1, 3, 0);
      add(1, 1, 1, 1, 32'h80,        32'h0000_0100, 1, 0, 0); // priority, epoch wraps 3->0
      add(0, 0, 1, 0, 32'h20,        32'h0000_0020, 1, 1, 0);
      add(1, 1, 0, 0, 32'h0,         32'h0000_0020, 0, 1, 0); // halt
      add(1, 0, 0, 0, 32'h0,         32'h0000_0020, 0, 1, 0);
      add(1, 1, 0, 0, 32'h0,         32'h0000_0020, 0, 1, 0);
      add(1, 0, 0, 0, 32'h0,         32'h0000_0020, 0, 1, 0);
      add(1, 0, 0, 0, 32'h0,         32'h0000_0020, 0, 1, 0);
      add(1, 0, 0, 0, 32'h0,         32'h0000_0020, 0, 1, 0);
      add(0, 0, 1, 0, 32'h200,       32'h0000_0200, 1, 2, 0); // wake by redirect
      add(0, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 3, 0);
      add(1, 0, 0, 0, 32'h0,         32'h0000_0000, 1, 3, 0); // address wrap
      add(1, 0, 0, 0, 32'h0,         32'h0000_0004, 1, 3, 0);
      add(0, 0, 1, 0, 32'h10,        32'h0000_0010, 1, 0, 0); // four redirects: epoch full circle
      add(0, 0, 1, 0, 32'h20,        32'h0000_0020, 1, 1, 0);
      add(0, 0, 1, 0, 32'h30,        32'h0000_0030, 1, 2, 0);
      add(0, 0, 1, 0, 32'h40,        32'h0000_0040, 1, 3, 0);
      add(0, 1, 0, 0, 32'h0,         32'h0000_0040, 0, 3, 0);
      add(0, 0, 1, 0, 32'h6,         32'h0000_0100, 1, 0, 1); // misaligned wake from HALTED
      add(0, 1, 0, 0, 32'h0,         32'h0000_0100, 0, 0, 0);
      add(0, 0, 0, 1, 32'h0,         32'h0000_0100, 1, 1, 0); // trap wake from HALTED
      add(1, 0, 0, 0, 32'h0,         32'h0000_0104, 1, 1, 0);

      rst = 1'b1;
      drive(0, 0, 0, 0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 32'h0, 1'b0, 2'd0, 1'b0);
      rst = 1'b0;
      #1;
      check_all("boot", 32'h0, 1'b0, 2'd0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].trig, vecs[i].halt, vecs[i].redir, vecs[i].trap, vecs[i].tgt);
         @(posedge clk);
         #1;
         check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_valid,
                   vecs[i].exp_ep, vecs[i].exp_fault);
      end

      // Asynchronous reset asserted mid-cycle while running.
      drive(1, 0, 0, 0, 32'h0);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check_all("async_rst", 32'h0, 1'b0, 2'd0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Redirect while in BOOT is honoured.
      drive(0, 0, 1, 0, 32'h80);
      @(posedge clk);
      #1;
      check_all("boot_redir", 32'h80, 1'b1, 2'd1, 1'b0);

      // 0x42 is misaligned for 4-byte but aligned for 2-byte instructions.
      drive(0, 0, 1, 0, 32'h42);
      @(posedge clk);
      #1;
      check_all("mis4", 32'h100, 1'b1, 2'd2, 1'b0 | 1'b1);
      chk("ib2.pc_out",         pc_out2,               32'h42);
      chk("ib2.pc_plus_inc",    pc_plus_inc2,          32'h44);
      chk("ib2.misalign_fault", 32'(misalign_fault2),  32'd0);
      chk("ib2.epoch",          32'(epoch2),           32'd2);
      chk("ib2.pc_valid",       32'(pc_valid2),        32'd1);

      drive(1, 0, 0, 0, 32'h0);
      @(posedge clk);
      #1;
      check_all("after_mis", 32'h104, 1'b1, 2'd2, 1'b0);
      chk("ib2.advance", pc_out2, 32'h44);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
